run_controller: RTL and testbench
=================================

// Module: run_controller
// PURPOSE
//  Top-level sequencer for the 9-bit-instruction CPU core. Replaces the open-coded START/HOLD/PROGRAM intent.
//  Tracks the testbench start handshake and holds the core (PC, register file, data memory) in reset for a fixed init window.
//  Then enables execution and stops on the decoder's halt/done or on a cycle-budget timeout.
//  Reports done, timeout and the executed-cycle count.
// PARAMETERS
//  INIT_CYCLES  4   cycles core_reset stays high in S_INIT (>=1)
//  CNT_W        32  width of cycle_count
//  MAX_CYCLES   0   run-cycle budget; 0 disables the timeout
// PORTS
//  clk          in   1      system clock
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      testbench start level (high = load/hold, falling = go)
//  halt         in   1      done/halt decode of the current instruction (control_decoder)
//  core_reset   out  1      synchronous reset to PC, register file, data memory
//  run_en       out  1      execution enable: gates PC update, reg write, mem write
//  done         out  1      program finished (halt or timeout); level
//  timeout      out  1      run ended by MAX_CYCLES, not by halt; level
//  cycle_count  out  CNT_W  number of S_RUN cycles in the current/last run
// BEHAVIOUR
//  Reset values: state=S_IDLE, core_reset=1, done=0, timeout=0, cycle_count=0, init_cnt=0.
//  All outputs registered except run_en = (state==S_RUN) && !halt (combinational, same cycle).
//  States:
//   S_IDLE : core_reset=1. start==1 -> S_INIT.
//   S_INIT : core_reset=1; done, timeout, cycle_count cleared on entry; init_cnt counts 0..INIT_CYCLES-1.
//            At init_cnt==INIT_CYCLES-1 -> S_HOLD. start is ignored until the window completes.
//   S_HOLD : core_reset=0, run_en=0. start==0 -> S_RUN. If start is already low, S_HOLD lasts exactly 1 cycle.
//   S_RUN  : run_en as above. cycle_count += 1 each cycle, including the halt cycle.
//            halt==1 -> S_DONE with done=1 and timeout=0 the next cycle.
//            MAX_CYCLES!=0 && cycle_count==MAX_CYCLES-1 && !halt -> S_DONE with done=1 and timeout=1.
//            Halt and budget in the same cycle: halt wins, timeout=0.
//            start==1 in S_RUN: ignored (no restart mid-program).
//   S_DONE : run_en=0, core_reset=0. done stays 1; cycle_count and timeout are frozen.
//            start==1 -> S_INIT, which starts a new run and clears the status outputs.
//  Cycle-level latency:
//   start sampled high at edge k -> S_INIT from k+1; core_reset stays high through edge k+INIT_CYCLES.
//   start sampled low in S_HOLD at edge j -> first run_en=1 cycle follows edge j.
//   halt sampled at edge h -> done=1 after edge h.
//  Width and wrap rules:
//   cycle_count saturates at all-ones; it never wraps.
//   init_cnt width = $clog2(INIT_CYCLES+1).
//  Async reset mid-run: immediate return to the reset values; the core is held in reset again.
//  Illegal state encodings decode to S_IDLE.
// STRUCTURE
//  Shared package cpu_ctrl_pkg:
//   typedef enum logic [2:0] {S_IDLE,S_INIT,S_HOLD,S_RUN,S_DONE} run_state_t
//   localparam defaults for INIT_CYCLES and MAX_CYCLES
//  One sub-module: sat_counter (clear, enable, saturating up-counter, param WIDTH).
//   Used for cycle_count; init_cnt stays inline.
//  top_level integration:
//   decoder done -> halt
//   run_en gates program_counter, register_file write_en and data_memory mem_write
//   core_reset ORed into their reset
// TESTING (INIT_CYCLES=4, MAX_CYCLES=0 unless noted)
//  1 Basic run: reset, start=1 for 6 cycles then 0, halt pulsed on the 10th S_RUN cycle
//    -> core_reset high exactly 4 cycles after S_INIT entry; run_en high for cycles 1..9, low in cycle 10;
//       done=1 from the next cycle; cycle_count=10; timeout=0.
//  2 Short start: start=1 for 1 cycle only -> full 4-cycle init still runs; S_HOLD lasts 1 cycle; then S_RUN.
//  3 Timeout: MAX_CYCLES=20, halt never asserted -> done=1 and timeout=1 after 20 run cycles; cycle_count=20.
//    Repeat with halt on cycle 20 -> timeout=0.
//  4 Back-to-back: after done, raise start -> done, timeout and cycle_count clear on S_INIT entry.
//    A second run with halt on cycle 3 gives cycle_count=3.
//  5 Reset mid-run: assert reset at S_RUN cycle 5 -> same cycle core_reset=1, run_en=0, done=0, cycle_count=0.
//    The controller returns to S_IDLE.
//  6 Saturation: CNT_W=4, MAX_CYCLES=0, halt on cycle 20 -> cycle_count holds 15; done=1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared state type and parameter defaults for the CPU run controller.
// Imported by the controller so the core-level integration sees the same encodings.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } run_state_t;

  localparam int unsigned INIT_CYCLES_DEF = 32'd4;
  localparam int unsigned CNT_W_DEF       = 32'd32;
  localparam int unsigned MAX_CYCLES_DEF  = 32'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/run_controller.sv
// Run sequencer for the 9-bit CPU core: holds the core in reset for a fixed init window,
// releases it on the falling start level, and stops on halt or on the cycle budget.
module run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MAX_CYCLES  = MAX_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  output logic             core_reset,
  output logic             run_en,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned     ICW         = $clog2(INIT_CYCLES + 1);
  localparam logic [ICW-1:0]  INIT_LAST   = ICW'(INIT_CYCLES - 1);
  localparam logic [63:0]     BUDGET_LAST = 64'(MAX_CYCLES) - 64'd1;

  run_state_t     r_state;
  logic [ICW-1:0] r_init_cnt;
  logic           r_core_reset;
  logic           r_done;
  logic           r_timeout;

  logic           w_new_run;
  logic           w_cnt_en;
  logic           w_budget_hit;
  logic [CNT_W-1:0] w_count;

  // A new run starts from IDLE or DONE; the counter is cleared on that same edge.
  assign w_new_run    = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_cnt_en     = (r_state == S_RUN);
  assign w_budget_hit = (MAX_CYCLES != 32'd0) && (64'(w_count) == BUDGET_LAST);

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_cycle_cnt (
    .clk    (clk),
    .rst    (reset),
    .i_clr  (w_new_run),
    .i_en   (w_cnt_en),
    .o_count(w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_init_cnt   <= '0;
      r_core_reset <= 1'b1;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_core_reset <= 1'b1;
          if (start) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
          end
        end
        S_INIT: begin
          // start is deliberately not looked at until the full window has elapsed
          if (r_init_cnt == INIT_LAST) begin
            r_state      <= S_HOLD;
            r_core_reset <= 1'b0;
          end else begin
            r_init_cnt   <= r_init_cnt + ICW'(1);
            r_core_reset <= 1'b1;
          end
        end
        S_HOLD: begin
          r_core_reset <= 1'b0;
          if (!start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_core_reset <= 1'b0;
          if (halt) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
          end else if (w_budget_hit) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        S_DONE: begin
          r_core_reset <= 1'b0;
          if (start) begin
            r_state      <= S_INIT;
            r_init_cnt   <= '0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_init_cnt   <= '0;
          r_core_reset <= 1'b1;
          r_done       <= 1'b0;
          r_timeout    <= 1'b0;
        end
      endcase
    end
  end

  // run_en must drop in the halt cycle itself, so it is not registered.
  assign run_en      = (r_state == S_RUN) && !halt;
  assign core_reset  = r_core_reset;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = w_count;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: three parameterisations checked every cycle against a
// phase-level reference model, with directed runs followed by randomized start/halt/reset.
module tb_run_controller;

  localparam int N       = 3;
  localparam int INIT_N  = 4;
  localparam int P_IDLE  = 0;
  localparam int P_INIT  = 1;
  localparam int P_HOLD  = 2;
  localparam int P_RUN   = 3;
  localparam int P_DONE  = 4;

  typedef struct {
    int     phase;
    int     init_n;
    longint cnt;
    int     rc;
    bit     to;
  } mdl_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] start_s, halt_s, crst_s, run_en_s, done_s, to_s;
  logic [31:0]  cc0_s, cc1_s;
  logic [3:0]   cc2_s;

  mdl_t mdl [N];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  run_controller #(.INIT_CYCLES(4), .CNT_W(32), .MAX_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .halt(halt_s[0]),
    .core_reset(crst_s[0]), .run_en(run_en_s[0]), .done(done_s[0]),
    .timeout(to_s[0]), .cycle_count(cc0_s));

  run_controller #(.INIT_CYCLES(4), .CNT_W(32), .MAX_CYCLES(20)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .halt(halt_s[1]),
    .core_reset(crst_s[1]), .run_en(run_en_s[1]), .done(done_s[1]),
    .timeout(to_s[1]), .cycle_count(cc1_s));

  run_controller #(.INIT_CYCLES(4), .CNT_W(4), .MAX_CYCLES(0)) u2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .halt(halt_s[2]),
    .core_reset(crst_s[2]), .run_en(run_en_s[2]), .done(done_s[2]),
    .timeout(to_s[2]), .cycle_count(cc2_s));

  function automatic longint max_of(input int i);
    return (i == 1) ? 64'd20 : 64'd0;
  endfunction

  function automatic longint cap_of(input int i);
    return (i == 2) ? 64'd15 : 64'd4294967295;
  endfunction

  function automatic longint cc_of(input int i);
    if (i == 0) return longint'(cc0_s);
    else if (i == 1) return longint'(cc1_s);
    else return longint'(cc2_s);
  endfunction

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic m_reset(input int i);
    mdl[i].phase  = P_IDLE;
    mdl[i].init_n = 0;
    mdl[i].cnt    = 0;
    mdl[i].rc     = 0;
    mdl[i].to     = 1'b0;
  endtask

  // One clock of the reference behaviour, driven by the inputs sampled at this edge.
  task automatic m_step(input int i);
    mdl_t m;
    bit   st, h, budget;
    m  = mdl[i];
    st = start_s[i];
    h  = halt_s[i];
    case (m.phase)
      P_IDLE, P_DONE: if (st) begin
        m.phase = P_INIT; m.init_n = 0; m.cnt = 0; m.rc = 0; m.to = 1'b0;
      end
      P_INIT: if (m.init_n == INIT_N - 1) m.phase = P_HOLD; else m.init_n++;
      P_HOLD: if (!st) m.phase = P_RUN;
      P_RUN: begin
        budget = (max_of(i) != 0) && (m.cnt == max_of(i) - 1);
        m.rc++;
        if (m.cnt < cap_of(i)) m.cnt++;
        if (h) begin m.phase = P_DONE; m.to = 1'b0; end
        else if (budget) begin m.phase = P_DONE; m.to = 1'b1; end
      end
      default: m.phase = P_IDLE;
    endcase
    mdl[i] = m;
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk("core_reset",  i, crst_s[i],   (mdl[i].phase == P_IDLE) || (mdl[i].phase == P_INIT));
      chk("run_en",      i, run_en_s[i], (mdl[i].phase == P_RUN) && !halt_s[i]);
      chk("done",        i, done_s[i],   mdl[i].phase == P_DONE);
      chk("timeout",     i, to_s[i],     mdl[i].to);
      chk("cycle_count", i, cc_of(i),    mdl[i].cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (reset) m_reset(i);
      else m_step(i);
    end
    @(negedge clk);
    check_all();
  endtask

  // Start high for slen cycles, halt each DUT on its run cycle h (0 = never), until all are done.
  task automatic run_prog(input int slen, input int h0, input int h1, input int h2,
                          output int cr_hi, output int first_run);
    int hs [N];
    int s;
    bit cr_fell, all_done;
    hs = '{h0, h1, h2};
    cr_hi = 0; first_run = -1; cr_fell = 1'b0; s = 0; all_done = 1'b0;
    while (!all_done && s < 300) begin
      start_s = (s < slen) ? 3'b111 : 3'b000;
      for (int i = 0; i < N; i++)
        halt_s[i] = (mdl[i].phase == P_RUN) && (mdl[i].rc + 1 == hs[i]);
      tick();
      s++;
      if (!cr_fell) begin
        if (crst_s[0]) cr_hi++;
        else cr_fell = 1'b1;
      end
      if (first_run < 0 && run_en_s[0]) first_run = s;
      all_done = (s >= slen);
      for (int i = 0; i < N; i++) if (mdl[i].phase != P_DONE) all_done = 1'b0;
    end
    halt_s  = '0;
    start_s = '0;
    chk("run_finished_in_budget", 0, all_done, 1);
  endtask

  initial begin
    int cr, fr, guard;
    start_s = '0;
    halt_s  = '0;
    reset   = 1'b1;
    for (int i = 0; i < N; i++) m_reset(i);
    tick();
    tick();
    chk("reset_core_reset_lit", 0, crst_s[0], 1);
    chk("reset_cc_lit",         0, cc_of(0),  0);
    reset = 1'b0;
    tick();

    // Basic run: halt on run cycle 10
    run_prog(6, 10, 10, 10, cr, fr);
    chk("t1_core_reset_cycles", 0, cr, 4);
    chk("t1_first_run_cycle",   0, fr, 7);
    chk("t1_cc_lit",            0, cc_of(0), 10);
    chk("t1_done_lit",          0, done_s[0], 1);
    chk("t1_timeout_lit",       0, to_s[0], 0);

    // Short start pulse: full init, single HOLD cycle
    run_prog(1, 5, 5, 5, cr, fr);
    chk("t2_core_reset_cycles", 0, cr, 4);
    chk("t2_first_run_cycle",   0, fr, 6);

    // Budget timeout on dut1, saturation on dut2
    run_prog(1, 25, 0, 20, cr, fr);
    chk("t3_timeout_lit", 1, to_s[1], 1);
    chk("t3_cc_lit",      1, cc_of(1), 20);
    chk("t6_sat_cc_lit",  2, cc_of(2), 15);
    chk("t6_sat_done_lit",2, done_s[2], 1);

    // Back-to-back: status clears on INIT entry
    start_s = '1;
    tick();
    chk("t4_clr_done_lit",    1, done_s[1], 0);
    chk("t4_clr_timeout_lit", 1, to_s[1],   0);
    chk("t4_clr_cc_lit",      1, cc_of(1),  0);
    run_prog(2, 3, 3, 3, cr, fr);
    chk("t4_cc_lit", 0, cc_of(0), 3);

    // Halt and budget in the same cycle: halt wins
    run_prog(1, 5, 20, 5, cr, fr);
    chk("t3b_timeout_lit", 1, to_s[1], 0);
    chk("t3b_cc_lit",      1, cc_of(1), 20);

    // Async reset in run cycle 5
    start_s = '1;
    tick();
    start_s = '0;
    guard = 0;
    while (!(mdl[0].phase == P_RUN && mdl[0].rc == 4) && guard < 100) begin
      tick();
      guard++;
    end
    chk("t5_reached_run", 0, guard < 100, 1);
    chk("t5_pre_run_en_lit", 0, run_en_s[0], 1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) m_reset(i);
    check_all();
    chk("t5_core_reset_lit", 0, crst_s[0],   1);
    chk("t5_run_en_lit",     0, run_en_s[0], 0);
    chk("t5_done_lit",       0, done_s[0],   0);
    chk("t5_cc_lit",         0, cc_of(0),    0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("t5_idle_core_reset_lit", 0, crst_s[0], 1);

    // Randomized start/halt levels with occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) start_s[i] = ~start_s[i];
        halt_s[i] = ($urandom_range(0, 23) == 0);
      end
      reset = ($urandom_range(0, 699) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
